control_unit: RTL and testbench
===============================

# control_unit

Hardwired Moore sequencer that drives the CPU datapath's control strobes. It fetches each instruction, decodes the 5-bit opcode from IR, and steps the T-state sequence for that instruction class. It replaces the hand-written per-instruction stimulus that benches use today. It sits beside `datapath` and connects strobe-for-strobe to its control ports.

## Interface
- `HALT_ON_UNDEF`, default 0: an undefined opcode is executed as `nop` when 0 and as `halt` when 1.

- `Clock`  in  1  system clock; all state changes occur on its rising edge.
- `Clear`  in  1  asynchronous, active-low reset (`Clear`=0 resets).
- `Stop`  in  1  halt request; level-sensitive.
- `opcode`  in  5  IR[31:27] from the datapath.
- `CON_FF`  in  1  branch-condition flip-flop from the datapath.
- `PCout`, `PCin`, `IncPC`  out  1 each  PC strobes.
- `MARin`, `MDRin`, `MDRout`, `Read`, `RAMin`  out  1 each  memory strobes; `RAMin` is the memory write enable.
- `IRin`, `Yin`, `ZLowIn`, `ZHighIn`, `ZLowout`, `ZHighout`  out  1 each  IR, Y and Z register strobes.
- `HIin`, `LOin`, `HIout`, `LOout`  out  1 each  HI/LO strobes.
- `GRA`, `GRB`, `GRC`, `BAout`, `Rin`, `Rout`, `Cout`  out  1 each  register-select and sign-extended constant strobes.
- `CONin`, `InPortOut`, `OutPortIn`  out  1 each  condition and I/O strobes.
- `Run`  out  1  high while executing; low in `RST` and `HALT`.

## Operation
- Outputs are a pure function of the present state (Moore). Every strobe not listed for a state is 0.
- Common prefix for every instruction:
  - `RST`: no strobes.
  - `F0`: `PCout`, `MARin`, `IncPC`, `ZLowIn`.
  - `F1`: `ZLowout`, `PCin`, `Read`, `MDRin`.
  - `F2`: `MDRout`, `IRin`.
  - `DEC`: no strobes. `opcode` is valid in this state; next state is chosen from it.
- `ld` 00000:
  - `T3`: `GRB`, `BAout`, `Yin`.
  - `T4`: `Cout`, `ZLowIn`.
  - `T5`: `ZLowout`, `MARin`.
  - `T6`: `Read`, `MDRin`.
  - `T7`: `MDRout`, `GRA`, `Rin`.
- `ldi` 00001: `T3`, `T4` as `ld`; `T5`: `ZLowout`, `GRA`, `Rin`.
- `st` 00010: `T3` to `T5` as `ld`; `T6`: `GRA`, `Rout`, `MDRin` (`Read`=0); `T7`: `RAMin`.
- `add` 00011, `sub` 00100, `and` 00101, `or` 00110:
  - `T3`: `GRB`, `Rout`, `Yin`.
  - `T4`: `GRC`, `Rout`, `ZLowIn`.
  - `T5`: `ZLowout`, `GRA`, `Rin`.
- `addi` 01100, `andi` 01101, `ori` 01110: as the three-register ALU ops, except `T4` is `Cout`, `ZLowIn`.
- `br` 10010:
  - `T3`: `GRA`, `Rout`, `CONin`.
  - `T4`: `PCout`, `Yin`.
  - `T5`: `Cout`, `ZLowIn`.
  - `T6`: `ZLowout`, `PCin` only if `CON_FF`=1; otherwise no strobes.
- `jr` 10011: `T3`: `GRA`, `Rout`, `PCin`.
- `in` 10110: `T3`: `InPortOut`, `GRA`, `Rin`.
- `out` 10111: `T3`: `GRA`, `Rout`, `OutPortIn`.
- `mfhi` 11000: `T3`: `HIout`, `GRA`, `Rin`. `mflo` 11001: `T3`: `LOout`, `GRA`, `Rin`.
- `nop` 11010: `DEC` goes directly to `F0`.
- `halt` 11011: `DEC` goes to `HALT`, which is absorbing until `Clear` is asserted.
- Undefined opcodes follow `HALT_ON_UNDEF`.
- The last state of every sequence goes to `F0`, except when `Stop`=1 in that state, in which case it goes to `HALT`. `Stop` is ignored in all other states.

## Timing
- `Clear`=0 forces `RST` immediately, mid-instruction included. All strobes and `Run` are 0 at once; no partial write completes afterwards.
- The first rising edge after `Clear` rises moves `RST` to `F0`. `Run`=1 from `F0` onward.
- One state per clock. Cycle counts including fetch and `DEC`:

  | Instruction | Cycles |
  |---|---|
  | `ld`, `st`, `br` | 9, 9, 8 |
  | `ldi`, ALU ops, immediate ops | 7 |
  | `jr`, `in`, `out`, `mfhi`, `mflo` | 5 |
  | `nop` | 4 |

- `CON_FF` is sampled only in `br` `T6`. It is stable there because `CONin` was loaded on the `T3` edge.
- `opcode` is sampled only in `DEC`, one cycle after the `IRin` edge.
- `RAMin` and `Read` are never high together. `PCin` and `PCout` are never high together.

## Test plan
- Release `Clear`, then `ld` with `opcode`=00000: `RST`, `F0` to `F2`, `DEC`, `T3` to `T7`. `MDRout`/`GRA`/`Rin` are high exactly in cycle 9; back in `F0` at cycle 10.
- `br` with `CON_FF`=1, then `br` with `CON_FF`=0: `PCin` pulses in `T6` only in the first case; both take 8 cycles.
- `st`: `RAMin` high only in `T7`; `Read` low in `T6`/`T7`; `MDRin` high in `T6`.
- `opcode`=11111 with `HALT_ON_UNDEF`=0: returns to `F0` after 4 cycles. With `HALT_ON_UNDEF`=1: enters `HALT`, `Run`=0 and stays there for 20 cycles.
- Assert `Stop` during `add` `T4`: no effect; assert it during `T5`: next state is `HALT`.
- Pulse `Clear` low during `ld` `T6`: all outputs 0 within the same cycle; after release, fetch restarts at `F0`.

Source files
------------

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Hardwired Moore sequencer driving the CPU datapath control strobes.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Stop,
  input  logic [4:0] opcode,
  input  logic       CON_FF,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       Read,
  output logic       RAMin,
  output logic       IRin,
  output logic       Yin,
  output logic       ZLowIn,
  output logic       ZHighIn,
  output logic       ZLowout,
  output logic       ZHighout,
  output logic       HIin,
  output logic       LOin,
  output logic       HIout,
  output logic       LOout,
  output logic       GRA,
  output logic       GRB,
  output logic       GRC,
  output logic       BAout,
  output logic       Rin,
  output logic       Rout,
  output logic       Cout,
  output logic       CONin,
  output logic       InPortOut,
  output logic       OutPortIn,
  output logic       Run
);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LD, C_LDI, C_ST, C_ALU, C_ALUI, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO
  } iclass_t;

  localparam int NSTB        = 29;
  localparam int B_PCOUT     = 0;
  localparam int B_PCIN      = 1;
  localparam int B_INCPC     = 2;
  localparam int B_MARIN     = 3;
  localparam int B_MDRIN     = 4;
  localparam int B_MDROUT    = 5;
  localparam int B_READ      = 6;
  localparam int B_RAMIN     = 7;
  localparam int B_IRIN      = 8;
  localparam int B_YIN       = 9;
  localparam int B_ZLOWIN    = 10;
  localparam int B_ZHIGHIN   = 11;
  localparam int B_ZLOWOUT   = 12;
  localparam int B_ZHIGHOUT  = 13;
  localparam int B_HIIN      = 14;
  localparam int B_LOIN      = 15;
  localparam int B_HIOUT     = 16;
  localparam int B_LOOUT     = 17;
  localparam int B_GRA       = 18;
  localparam int B_GRB       = 19;
  localparam int B_GRC       = 20;
  localparam int B_BAOUT     = 21;
  localparam int B_RIN       = 22;
  localparam int B_ROUT      = 23;
  localparam int B_COUT      = 24;
  localparam int B_CONIN     = 25;
  localparam int B_INPORTOUT = 26;
  localparam int B_OUTPORTIN = 27;
  localparam int B_RUN       = 28;

  state_t            state_q, state_d;
  iclass_t           class_q, class_d;
  logic [NSTB-1:0]   stb_q, stb_d;
  iclass_t           dec_class;
  logic              dec_halt;
  logic              last;

  always_comb begin
    dec_class = C_NONE;
    dec_halt  = 1'b0;
    case (opcode)
      5'b00000:                     dec_class = C_LD;
      5'b00001:                     dec_class = C_LDI;
      5'b00010:                     dec_class = C_ST;
      5'b00011, 5'b00100,
      5'b00101, 5'b00110:           dec_class = C_ALU;
      5'b01100, 5'b01101, 5'b01110: dec_class = C_ALUI;
      5'b10010:                     dec_class = C_BR;
      5'b10011:                     dec_class = C_JR;
      5'b10110:                     dec_class = C_IN;
      5'b10111:                     dec_class = C_OUT;
      5'b11000:                     dec_class = C_MFHI;
      5'b11001:                     dec_class = C_MFLO;
      5'b11010:                     dec_class = C_NONE;
      5'b11011:                     dec_halt  = 1'b1;
      default:                      dec_halt  = HALT_ON_UNDEF;
    endcase
  end

  // Final T-state of each class; only there may Stop divert to HALT.
  always_comb begin
    case (class_q)
      C_LD, C_ST:           last = (state_q == S_T7);
      C_BR:                 last = (state_q == S_T6);
      C_LDI, C_ALU, C_ALUI: last = (state_q == S_T5);
      default:              last = (state_q == S_T3);
    endcase
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_RST:  state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_DEC;
      S_DEC: begin
        class_d = dec_class;
        if (dec_halt)                 state_d = S_HALT;
        else if (dec_class == C_NONE) state_d = S_F0;
        else                          state_d = S_T3;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        if (last) begin
          state_d = Stop ? S_HALT : S_F0;
        end else begin
          case (state_q)
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T7;
            default: state_d = S_F0;
          endcase
        end
      end
    endcase
  end

  // Strobes are decoded from the state being entered so they appear registered
  // in that state; CON_FF is already stable by the edge into br T6.
  always_comb begin
    stb_d        = '0;
    stb_d[B_RUN] = (state_d != S_RST) && (state_d != S_HALT);
    case (state_d)
      S_F0: begin
        stb_d[B_PCOUT] = 1'b1; stb_d[B_MARIN] = 1'b1;
        stb_d[B_INCPC] = 1'b1; stb_d[B_ZLOWIN] = 1'b1;
      end
      S_F1: begin
        stb_d[B_ZLOWOUT] = 1'b1; stb_d[B_PCIN] = 1'b1;
        stb_d[B_READ]    = 1'b1; stb_d[B_MDRIN] = 1'b1;
      end
      S_F2: begin
        stb_d[B_MDROUT] = 1'b1; stb_d[B_IRIN] = 1'b1;
      end
      S_T3: begin
        case (class_d)
          C_LD, C_LDI, C_ST: begin
            stb_d[B_GRB] = 1'b1; stb_d[B_BAOUT] = 1'b1; stb_d[B_YIN] = 1'b1;
          end
          C_ALU, C_ALUI: begin
            stb_d[B_GRB] = 1'b1; stb_d[B_ROUT] = 1'b1; stb_d[B_YIN] = 1'b1;
          end
          C_BR: begin
            stb_d[B_GRA] = 1'b1; stb_d[B_ROUT] = 1'b1; stb_d[B_CONIN] = 1'b1;
          end
          C_JR: begin
            stb_d[B_GRA] = 1'b1; stb_d[B_ROUT] = 1'b1; stb_d[B_PCIN] = 1'b1;
          end
          C_IN: begin
            stb_d[B_INPORTOUT] = 1'b1; stb_d[B_GRA] = 1'b1; stb_d[B_RIN] = 1'b1;
          end
          C_OUT: begin
            stb_d[B_GRA] = 1'b1; stb_d[B_ROUT] = 1'b1; stb_d[B_OUTPORTIN] = 1'b1;
          end
          C_MFHI: begin
            stb_d[B_HIOUT] = 1'b1; stb_d[B_GRA] = 1'b1; stb_d[B_RIN] = 1'b1;
          end
          C_MFLO: begin
            stb_d[B_LOOUT] = 1'b1; stb_d[B_GRA] = 1'b1; stb_d[B_RIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (class_d)
          C_LD, C_LDI, C_ST, C_ALUI: begin
            stb_d[B_COUT] = 1'b1; stb_d[B_ZLOWIN] = 1'b1;
          end
          C_ALU: begin
            stb_d[B_GRC] = 1'b1; stb_d[B_ROUT] = 1'b1; stb_d[B_ZLOWIN] = 1'b1;
          end
          C_BR: begin
            stb_d[B_PCOUT] = 1'b1; stb_d[B_YIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (class_d)
          C_LD, C_ST: begin
            stb_d[B_ZLOWOUT] = 1'b1; stb_d[B_MARIN] = 1'b1;
          end
          C_LDI, C_ALU, C_ALUI: begin
            stb_d[B_ZLOWOUT] = 1'b1; stb_d[B_GRA] = 1'b1; stb_d[B_RIN] = 1'b1;
          end
          C_BR: begin
            stb_d[B_COUT] = 1'b1; stb_d[B_ZLOWIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (class_d)
          C_LD: begin
            stb_d[B_READ] = 1'b1; stb_d[B_MDRIN] = 1'b1;
          end
          C_ST: begin
            stb_d[B_GRA] = 1'b1; stb_d[B_ROUT] = 1'b1; stb_d[B_MDRIN] = 1'b1;
          end
          C_BR: begin
            stb_d[B_ZLOWOUT] = CON_FF; stb_d[B_PCIN] = CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (class_d)
          C_LD: begin
            stb_d[B_MDROUT] = 1'b1; stb_d[B_GRA] = 1'b1; stb_d[B_RIN] = 1'b1;
          end
          C_ST:    stb_d[B_RAMIN] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_RST;
      class_q <= C_NONE;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      stb_q   <= stb_d;
    end
  end

  assign PCout     = stb_q[B_PCOUT];
  assign PCin      = stb_q[B_PCIN];
  assign IncPC     = stb_q[B_INCPC];
  assign MARin     = stb_q[B_MARIN];
  assign MDRin     = stb_q[B_MDRIN];
  assign MDRout    = stb_q[B_MDROUT];
  assign Read      = stb_q[B_READ];
  assign RAMin     = stb_q[B_RAMIN];
  assign IRin      = stb_q[B_IRIN];
  assign Yin       = stb_q[B_YIN];
  assign ZLowIn    = stb_q[B_ZLOWIN];
  assign ZHighIn   = stb_q[B_ZHIGHIN];
  assign ZLowout   = stb_q[B_ZLOWOUT];
  assign ZHighout  = stb_q[B_ZHIGHOUT];
  assign HIin      = stb_q[B_HIIN];
  assign LOin      = stb_q[B_LOIN];
  assign HIout     = stb_q[B_HIOUT];
  assign LOout     = stb_q[B_LOOUT];
  assign GRA       = stb_q[B_GRA];
  assign GRB       = stb_q[B_GRB];
  assign GRC       = stb_q[B_GRC];
  assign BAout     = stb_q[B_BAOUT];
  assign Rin       = stb_q[B_RIN];
  assign Rout      = stb_q[B_ROUT];
  assign Cout      = stb_q[B_COUT];
  assign CONin     = stb_q[B_CONIN];
  assign InPortOut = stb_q[B_INPORTOUT];
  assign OutPortIn = stb_q[B_OUTPORTIN];
  assign Run       = stb_q[B_RUN];

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Self-checking bench for control_unit (both HALT_ON_UNDEF settings).
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  localparam logic [28:0] M_PCOUT  = 29'd1 << 0;
  localparam logic [28:0] M_PCIN   = 29'd1 << 1;
  localparam logic [28:0] M_INCPC  = 29'd1 << 2;
  localparam logic [28:0] M_MARIN  = 29'd1 << 3;
  localparam logic [28:0] M_MDRIN  = 29'd1 << 4;
  localparam logic [28:0] M_MDROUT = 29'd1 << 5;
  localparam logic [28:0] M_READ   = 29'd1 << 6;
  localparam logic [28:0] M_RAMIN  = 29'd1 << 7;
  localparam logic [28:0] M_IRIN   = 29'd1 << 8;
  localparam logic [28:0] M_YIN    = 29'd1 << 9;
  localparam logic [28:0] M_ZLIN   = 29'd1 << 10;
  localparam logic [28:0] M_ZLOUT  = 29'd1 << 12;
  localparam logic [28:0] M_HIOUT  = 29'd1 << 16;
  localparam logic [28:0] M_LOOUT  = 29'd1 << 17;
  localparam logic [28:0] M_GRA    = 29'd1 << 18;
  localparam logic [28:0] M_GRB    = 29'd1 << 19;
  localparam logic [28:0] M_GRC    = 29'd1 << 20;
  localparam logic [28:0] M_BAOUT  = 29'd1 << 21;
  localparam logic [28:0] M_RIN    = 29'd1 << 22;
  localparam logic [28:0] M_ROUT   = 29'd1 << 23;
  localparam logic [28:0] M_COUT   = 29'd1 << 24;
  localparam logic [28:0] M_CONIN  = 29'd1 << 25;
  localparam logic [28:0] M_INPO   = 29'd1 << 26;
  localparam logic [28:0] M_OUTPI  = 29'd1 << 27;
  localparam logic [28:0] M_RUN    = 29'd1 << 28;

  logic       Clock = 1'b0;
  logic       Clear = 1'b0;
  logic       Stop = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       CON_FF = 1'b0;
  wire [28:0] o0, o1;

  always #5 Clock = ~Clock;

  control_unit #(.HALT_ON_UNDEF(1'b0)) dut0 (
    .Clock(Clock), .Clear(Clear), .Stop(Stop), .opcode(opcode), .CON_FF(CON_FF),
    .PCout(o0[0]), .PCin(o0[1]), .IncPC(o0[2]), .MARin(o0[3]), .MDRin(o0[4]),
    .MDRout(o0[5]), .Read(o0[6]), .RAMin(o0[7]), .IRin(o0[8]), .Yin(o0[9]),
    .ZLowIn(o0[10]), .ZHighIn(o0[11]), .ZLowout(o0[12]), .ZHighout(o0[13]),
    .HIin(o0[14]), .LOin(o0[15]), .HIout(o0[16]), .LOout(o0[17]), .GRA(o0[18]),
    .GRB(o0[19]), .GRC(o0[20]), .BAout(o0[21]), .Rin(o0[22]), .Rout(o0[23]),
    .Cout(o0[24]), .CONin(o0[25]), .InPortOut(o0[26]), .OutPortIn(o0[27]),
    .Run(o0[28])
  );

  control_unit #(.HALT_ON_UNDEF(1'b1)) dut1 (
    .Clock(Clock), .Clear(Clear), .Stop(Stop), .opcode(opcode), .CON_FF(CON_FF),
    .PCout(o1[0]), .PCin(o1[1]), .IncPC(o1[2]), .MARin(o1[3]), .MDRin(o1[4]),
    .MDRout(o1[5]), .Read(o1[6]), .RAMin(o1[7]), .IRin(o1[8]), .Yin(o1[9]),
    .ZLowIn(o1[10]), .ZHighIn(o1[11]), .ZLowout(o1[12]), .ZHighout(o1[13]),
    .HIin(o1[14]), .LOin(o1[15]), .HIout(o1[16]), .LOout(o1[17]), .GRA(o1[18]),
    .GRB(o1[19]), .GRC(o1[20]), .BAout(o1[21]), .Rin(o1[22]), .Rout(o1[23]),
    .Cout(o1[24]), .CONin(o1[25]), .InPortOut(o1[26]), .OutPortIn(o1[27]),
    .Run(o1[28])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each instruction is a list of expected strobe words,
  // bit 29 marks the instruction's own T-states (where Stop may act).
  logic [29:0] q0[$];
  logic [29:0] q1[$];
  logic [29:0] cur[2];
  bit          rst_m[2];
  bit          halted[2];
  bit          ends_halt[2];
  logic [4:0]  run_opc[2];
  int          pos[2];
  logic [4:0]  nxt_opc;
  logic        nxt_con;
  bit          picked, pending;
  logic [4:0]  src_opc[$];
  logic        src_con[$];
  int          stop_mode = 0;
  int          len_q[$];
  int          mlen = 0;

  typedef struct {
    logic [4:0] opc;
    logic       con;
    int         cycles;
  } vec_t;
  vec_t tv[19];

  task automatic chk(input string nm, input logic [28:0] act, input logic [28:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit is_defined(input logic [4:0] opc);
    return opc inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13,
                       5'd14, 5'd18, 5'd19, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27};
  endfunction

  function automatic void push_w(input int d, input logic [28:0] w, input bit body);
    if (d == 0) q0.push_back({body, w | M_RUN});
    else        q1.push_back({body, w | M_RUN});
  endfunction

  function automatic void pop_cur(input int d);
    if (d == 0) cur[0] = q0.pop_front();
    else        cur[1] = q1.pop_front();
    pos[d]++;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void pick();
    if (src_opc.size() > 0) begin
      nxt_opc = src_opc.pop_front();
      nxt_con = src_con.pop_front();
    end else begin
      nxt_opc = 5'($urandom_range(0, 31));
      nxt_con = 1'($urandom_range(0, 1));
    end
    pending = 1'b1;
  endfunction

  function automatic void start_instr(input int d);
    if (!picked) begin
      pick();
      picked = 1'b1;
    end
    run_opc[d] = nxt_opc;
    pos[d]     = -1;
    push_w(d, M_PCOUT | M_MARIN | M_INCPC | M_ZLIN, 1'b0);
    push_w(d, M_ZLOUT | M_PCIN | M_READ | M_MDRIN, 1'b0);
    push_w(d, M_MDROUT | M_IRIN, 1'b0);
    push_w(d, 29'd0, 1'b0);
    case (nxt_opc)
      5'd0, 5'd1, 5'd2: begin
        push_w(d, M_GRB | M_BAOUT | M_YIN, 1'b1);
        push_w(d, M_COUT | M_ZLIN, 1'b1);
        if (nxt_opc == 5'd1) push_w(d, M_ZLOUT | M_GRA | M_RIN, 1'b1);
        else                 push_w(d, M_ZLOUT | M_MARIN, 1'b1);
        if (nxt_opc == 5'd0) begin
          push_w(d, M_READ | M_MDRIN, 1'b1);
          push_w(d, M_MDROUT | M_GRA | M_RIN, 1'b1);
        end else if (nxt_opc == 5'd2) begin
          push_w(d, M_GRA | M_ROUT | M_MDRIN, 1'b1);
          push_w(d, M_RAMIN, 1'b1);
        end
      end
      5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14: begin
        push_w(d, M_GRB | M_ROUT | M_YIN, 1'b1);
        if (nxt_opc < 5'd12) push_w(d, M_GRC | M_ROUT | M_ZLIN, 1'b1);
        else                 push_w(d, M_COUT | M_ZLIN, 1'b1);
        push_w(d, M_ZLOUT | M_GRA | M_RIN, 1'b1);
      end
      5'd18: begin
        push_w(d, M_GRA | M_ROUT | M_CONIN, 1'b1);
        push_w(d, M_PCOUT | M_YIN, 1'b1);
        push_w(d, M_COUT | M_ZLIN, 1'b1);
        push_w(d, nxt_con ? (M_ZLOUT | M_PCIN) : 29'd0, 1'b1);
      end
      5'd19: push_w(d, M_GRA | M_ROUT | M_PCIN, 1'b1);
      5'd22: push_w(d, M_INPO | M_GRA | M_RIN, 1'b1);
      5'd23: push_w(d, M_GRA | M_ROUT | M_OUTPI, 1'b1);
      5'd24: push_w(d, M_HIOUT | M_GRA | M_RIN, 1'b1);
      5'd25: push_w(d, M_LOOUT | M_GRA | M_RIN, 1'b1);
      default: ;
    endcase
    ends_halt[d] = (nxt_opc == 5'd27) || (!is_defined(nxt_opc) && d == 1);
  endfunction

  function automatic void model_reset(input int d);
    cur[d]    = '0;
    rst_m[d]  = 1'b1;
    halted[d] = 1'b0;
    if (d == 0) q0.delete(); else q1.delete();
  endfunction

  function automatic void advance(input int d);
    if (!Clear) begin
      model_reset(d);
    end else if (rst_m[d]) begin
      rst_m[d] = 1'b0;
      start_instr(d);
      pop_cur(d);
    end else if (halted[d]) begin
      cur[d] = '0;
    end else if (qsize(d) > 0) begin
      pop_cur(d);
    end else if (ends_halt[d] || (Stop && cur[d][29])) begin
      halted[d] = 1'b1;
      cur[d]    = '0;
    end else begin
      start_instr(d);
      pop_cur(d);
    end
  endfunction

  task automatic tick(input bit clr);
    @(negedge Clock);
    chk("dut0_strobes", o0, cur[0][28:0]);
    chk("dut1_strobes", o1, cur[1][28:0]);
    if (o0[2]) begin
      if (mlen > 0) len_q.push_back(mlen);
      mlen = 1;
    end else if (mlen > 0) begin
      mlen++;
    end
    if (pending) begin
      opcode  = nxt_opc;
      CON_FF  = nxt_con;
      pending = 1'b0;
    end
    Clear = clr;
    if (cur[0][29] && !halted[0]) begin
      case (stop_mode)
        1:       Stop = ($urandom_range(0, 5) == 0);
        2:       Stop = (run_opc[0] == 5'd3);
        default: Stop = 1'b0;
      endcase
    end else begin
      Stop = 1'b0;
    end
    picked = 1'b0;
    advance(0);
    advance(1);
  endtask

  initial begin
    int n, h1;
    bit found;
    tv[0]  = '{5'b00000, 1'b0, 9};  tv[1]  = '{5'b00001, 1'b0, 7};
    tv[2]  = '{5'b00010, 1'b0, 9};  tv[3]  = '{5'b00011, 1'b0, 7};
    tv[4]  = '{5'b00100, 1'b0, 7};  tv[5]  = '{5'b00101, 1'b0, 7};
    tv[6]  = '{5'b00110, 1'b0, 7};  tv[7]  = '{5'b01100, 1'b0, 7};
    tv[8]  = '{5'b01101, 1'b0, 7};  tv[9]  = '{5'b01110, 1'b0, 7};
    tv[10] = '{5'b10010, 1'b1, 8};  tv[11] = '{5'b10010, 1'b0, 8};
    tv[12] = '{5'b10011, 1'b0, 5};  tv[13] = '{5'b10110, 1'b0, 5};
    tv[14] = '{5'b10111, 1'b0, 5};  tv[15] = '{5'b11000, 1'b0, 5};
    tv[16] = '{5'b11001, 1'b0, 5};  tv[17] = '{5'b11010, 1'b0, 4};
    tv[18] = '{5'b11111, 1'b0, 4};
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      pos[d] = 0;
      run_opc[d] = 5'd0;
      ends_halt[d] = 1'b0;
    end
    picked = 1'b0;
    pending = 1'b0;
    foreach (tv[i]) begin
      src_opc.push_back(tv[i].opc);
      src_con.push_back(tv[i].con);
    end

    // Reset held, then released: table of instructions back to back.
    repeat (3) tick(1'b0);
    n = 0;
    while (len_q.size() < 19 && n < 400) begin
      tick(1'b1);
      n++;
    end
    foreach (tv[i]) begin
      chk_int($sformatf("len_op%0d_con%0d", tv[i].opc, tv[i].con),
              (i < len_q.size()) ? len_q[i] : -1, tv[i].cycles);
    end

    // Undefined opcode with HALT_ON_UNDEF=1 leaves dut1 parked in HALT.
    n = 0;
    repeat (20) begin
      tick(1'b1);
      if (o1[28]) n++;
    end
    chk_int("undef_halt_hold_run_cycles", n, 0);

    // Stop held through add: ignored in T3/T4, honoured in T5.
    tick(1'b0);
    src_opc.push_back(5'd3);
    src_con.push_back(1'b0);
    stop_mode = 2;
    tick(1'b1);
    n = 0;
    while (!halted[0] && n < 40) begin
      tick(1'b1);
      n++;
    end
    tick(1'b1);
    chk("stop_add_t5_halts_run", o0[28], 1'b0);
    stop_mode = 0;

    // Clear pulsed mid-cycle during ld T6.
    tick(1'b0);
    src_opc.push_back(5'd0);
    src_con.push_back(1'b0);
    tick(1'b1);
    n = 0;
    found = 1'b0;
    while (!found && n < 60) begin
      tick(1'b1);
      n++;
      found = (run_opc[0] == 5'd0) && (pos[0] == 8) && !halted[0];
    end
    chk("ld_t6_reached", {28'd0, found}, 29'd1);
    #2;
    Clear = 1'b0;
    #1;
    chk("clear_async_dut0", o0, 29'd0);
    chk("clear_async_dut1", o1, 29'd0);
    model_reset(0);
    model_reset(1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    chk("refetch_f0_after_clear", o0, M_PCOUT | M_MARIN | M_INCPC | M_ZLIN | M_RUN);

    // Randomized opcodes, CON_FF and Stop against the model.
    stop_mode = 1;
    h1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (halted[1]) h1++; else h1 = 0;
      if (h1 >= 25 || (halted[0] && halted[1] && h1 >= 3)) begin
        tick(1'b0);
        h1 = 0;
      end else begin
        tick(1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
